fpu_postproc_arb: RTL

- Arbitrates the single shared FPU post-processing/rounding stage among three result producers: the FMA pipeline, the iterative div/sqrt unit and the convert unit.
- Each cycle it grants at most one source and registers a one-hot FmaOp/DivOp/CvtOp select, the rounding sign Ms and the destination tag.
- Provides a 1-entry skid buffer for the div/sqrt completion pulse and an aging counter so convert cannot starve behind FMA.
- Sits between the execute-stage FPU units and the post-processing block.

---
 rtl/fpu_postproc_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fpu_postproc_arb.sv
// Shared FPU post-processing arbiter: FMA, div/sqrt (1-entry skid) and convert.
// Registers a one-hot op select, rounding sign and destination tag.
module fpu_postproc_arb #(
    parameter int TAGW   = 5,
    parameter int AGEMAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FlushE,
    input  logic            FmaValid,
    input  logic            FmaSs,
    input  logic [TAGW-1:0] FmaTag,
    output logic            FmaReady,
    input  logic            CvtValid,
    input  logic            CvtCs,
    input  logic [TAGW-1:0] CvtTag,
    output logic            CvtReady,
    input  logic            DivDone,
    input  logic            Xs,
    input  logic            Ys,
    input  logic            Sqrt,
    input  logic [TAGW-1:0] DivTag,
    output logic            DivReady,
    output logic            PostValid,
    input  logic            PostReady,
    output logic            FmaOp,
    output logic            DivOp,
    output logic            CvtOp,
    output logic            Ms,
    output logic [TAGW-1:0] PostTag,
    output logic            DivOverrun
);

    localparam logic [3:0] AGE_MAX = 4'(AGEMAX);

    logic            pv_q, pv_d;
    logic [2:0]      op_q, op_d;
    logic            ms_q, ms_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            full_q, full_d;
    logic            qs_q, qs_d;
    logic [TAGW-1:0] btag_q, btag_d;
    logic [3:0]      age_q, age_d;
    logic            ovr_q, ovr_d;

    logic free, aged, g_div, g_fma, g_cvt;

    always_comb begin
        free  = ~pv_q | PostReady;
        aged  = CvtValid && (age_q == AGE_MAX);
        g_div = 1'b0;
        g_fma = 1'b0;
        g_cvt = 1'b0;
        if (free && !FlushE) begin
            g_div = full_q;
            g_cvt = !full_q && CvtValid && (aged || !FmaValid);
            g_fma = !full_q && FmaValid && !aged;
        end
    end

    always_comb begin
        pv_d   = pv_q;
        op_d   = op_q;
        ms_d   = ms_q;
        tag_d  = tag_q;
        full_d = full_q;
        qs_d   = qs_q;
        btag_d = btag_q;
        age_d  = age_q;
        ovr_d  = ovr_q | (DivDone & full_q);
        if (FlushE) begin
            pv_d   = 1'b0;
            op_d   = 3'b000;
            ms_d   = 1'b0;
            full_d = 1'b0;
            age_d  = 4'd0;
        end else begin
            // Capture only into an empty buffer; a pulse while full is dropped.
            if (DivDone && !full_q) begin
                full_d = 1'b1;
                qs_d   = Xs ^ (Ys & ~Sqrt);
                btag_d = DivTag;
            end
            if (g_div) begin
                pv_d   = 1'b1;
                op_d   = 3'b010;
                ms_d   = qs_q;
                tag_d  = btag_q;
                full_d = 1'b0;
            end else if (g_fma) begin
                pv_d  = 1'b1;
                op_d  = 3'b100;
                ms_d  = FmaSs;
                tag_d = FmaTag;
            end else if (g_cvt) begin
                pv_d  = 1'b1;
                op_d  = 3'b001;
                ms_d  = CvtCs;
                tag_d = CvtTag;
            end else if (PostReady) begin
                pv_d = 1'b0;
                op_d = 3'b000;
                ms_d = 1'b0;
            end
            if (!CvtValid || g_cvt) begin
                age_d = 4'd0;
            end else if (free && age_q != AGE_MAX) begin
                age_d = age_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q   <= 1'b0;
            op_q   <= 3'b000;
            ms_q   <= 1'b0;
            tag_q  <= '0;
            full_q <= 1'b0;
            qs_q   <= 1'b0;
            btag_q <= '0;
            age_q  <= 4'd0;
            ovr_q  <= 1'b0;
        end else begin
            pv_q   <= pv_d;
            op_q   <= op_d;
            ms_q   <= ms_d;
            tag_q  <= tag_d;
            full_q <= full_d;
            qs_q   <= qs_d;
            btag_q <= btag_d;
            age_q  <= age_d;
            ovr_q  <= ovr_d;
        end
    end

    assign FmaReady   = g_fma;
    assign CvtReady   = g_cvt;
    assign DivReady   = ~full_q;
    assign PostValid  = pv_q;
    assign FmaOp      = op_q[2];
    assign DivOp      = op_q[1];
    assign CvtOp      = op_q[0];
    assign Ms         = ms_q;
    assign PostTag    = tag_q;
    assign DivOverrun = ovr_q;

endmodule
